// File: rtl/gpu_instr_pkg.sv
// Shared GPU instruction definitions: opcodes, frame geometry and receiver states.
// Latency: none (declarations only).
// Backpressure: none (declarations only). Optional macro: INSTR_CHECKSUM_EN adds the S_CHK state.
package gpu_instr_pkg;

    localparam int INSTR_W     = 32;
    localparam int FRAME_BYTES = 4;

    localparam logic [7:0] SET_BG_COLOR       = 8'h01;
    localparam logic [7:0] SET_RED_BG_COLOR   = 8'h02;
    localparam logic [7:0] SET_GREEN_BG_COLOR = 8'h03;
    localparam logic [7:0] SET_BLUE_BG_COLOR  = 8'h04;
    localparam logic [7:0] SET_BLACK_BG_COLOR = 8'h05;
    localparam logic [7:0] SET_WHITE_BG_COLOR = 8'h06;

    // One state per expected byte; S_CHK waits for the trailing XOR byte.
    typedef enum logic [2:0] {
        S_B0,
        S_B1,
        S_B2,
        S_B3
`ifdef INSTR_CHECKSUM_EN
        , S_CHK
`endif
    } rx_state_e;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle timer: counts clocks while a frame is in progress, pulses on expiry.
// Latency: o_expired is combinational from the count register (expires TIMEOUT_CYCLES-1 idle clocks after clear).
// Backpressure: none; i_clear always wins over expiry.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expiry is suppressed when a byte arrives the same cycle (clear has priority).
    assign o_expired = i_enable && !i_clear && (cnt_q == LAST);

    // Next count: restart on clear or expiry, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || o_expired) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_receiver.sv
// Assembles little-endian 32-bit GPU instructions from a UART byte stream; drops stale partial frames.
// Latency: 1 clock from the final byte to o_instruction/o_instruction_ready.
// Backpressure: none; every valid byte is accepted. Optional macro: INSTR_CHECKSUM_EN (trailing XOR byte).
module instruction_receiver
    import gpu_instr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instruction_ready,
    output logic               o_busy,
    output logic [7:0]         o_error_count
);

`ifdef INSTR_CHECKSUM_EN
    localparam int DATA_W = INSTR_W;
`else
    // The last byte goes straight to the output register, so only three are buffered.
    localparam int DATA_W = INSTR_W - 8;
`endif

    rx_state_e          state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               rdy_q, rdy_d;
    logic [7:0]         err_q, err_d;
    logic               err_inc;
    logic               expired;
`ifdef INSTR_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_byte_valid || (state_q == S_B0)),
        .i_enable  (state_q != S_B0),
        .o_expired (expired)
    );

    assign o_instruction       = instr_q;
    assign o_instruction_ready = rdy_q;
    assign o_busy              = (state_q != S_B0);
    assign o_error_count       = err_q;

    // Byte placement, frame completion, timeout abort and error accounting.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        instr_d = instr_q;
        rdy_d   = 1'b0;
        err_inc = 1'b0;
`ifdef INSTR_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        if (i_byte_valid) begin
            case (state_q)
                S_B0: begin
                    data_d[7:0] = i_byte;
                    state_d     = S_B1;
`ifdef INSTR_CHECKSUM_EN
                    chk_d       = i_byte;
`endif
                end
                S_B1: begin
                    data_d[15:8] = i_byte;
                    state_d      = S_B2;
`ifdef INSTR_CHECKSUM_EN
                    chk_d        = chk_q ^ i_byte;
`endif
                end
                S_B2: begin
                    data_d[23:16] = i_byte;
                    state_d       = S_B3;
`ifdef INSTR_CHECKSUM_EN
                    chk_d         = chk_q ^ i_byte;
`endif
                end
                S_B3: begin
`ifdef INSTR_CHECKSUM_EN
                    data_d[31:24] = i_byte;
                    chk_d         = chk_q ^ i_byte;
                    state_d       = S_CHK;
`else
                    instr_d = {i_byte, data_q[23:0]};
                    rdy_d   = 1'b1;
                    state_d = S_B0;
`endif
                end
`ifdef INSTR_CHECKSUM_EN
                S_CHK: begin
                    if (i_byte == chk_q) begin
                        instr_d = data_q;
                        rdy_d   = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                    state_d = S_B0;
                end
`endif
                default: state_d = S_B0;
            endcase
        end else if (expired) begin
            state_d = S_B0;
            err_inc = 1'b1;
        end
        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    // State, assembly buffer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_B0;
            data_q  <= '0;
            instr_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            instr_q <= instr_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

`ifdef INSTR_CHECKSUM_EN
    // Running XOR of the four payload bytes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

endmodule

// File: doc/instruction_receiver.md
# instruction_receiver

Assembles 32-bit GPU instructions from the byte stream delivered by the UART receiver. It presents each instruction to `pixel_generator` as a 32-bit word with a one-cycle ready strobe. Partial frames are discarded after an inter-byte timeout, and a saturating error counter records dropped frames. The block sits between the serial front end and `pixel_generator`, in the pixel clock domain.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle clocks allowed between bytes of one frame before the partial frame is dropped. Minimum 2.
- `i_clk`  in  1  pixel clock, shared with `pixel_generator`.
- `i_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_byte`  in  8  received byte.
- `i_byte_valid`  in  1  `i_byte` is valid this cycle. Single-cycle strobe; back-to-back cycles are legal.
- `o_instruction`  out  32  assembled instruction. Bits [7:0] are the opcode; bits [31:8] are the arguments.
- `o_instruction_ready`  out  1  one-cycle strobe: `o_instruction` is new.
- `o_busy`  out  1  a frame is partially received (state is not `S_B0`).
- `o_error_count`  out  8  dropped frames, saturating at 255.

## Operation
- Frame format, little-endian: byte0 → [7:0] (opcode), byte1 → [15:8], byte2 → [23:16], byte3 → [31:24].
- FSM states: `S_B0`, `S_B1`, `S_B2`, `S_B3`, plus `S_CHK` when the checksum feature is compiled in. Reset state is `S_B0`.
- Transitions: each accepted byte advances one state.
  - Without `S_CHK`, a byte accepted in `S_B3` completes the frame. The state returns to `S_B0`.
  - With `S_CHK`, the byte accepted in `S_CHK` completes the frame. The state returns to `S_B0`.
- Opcodes are not validated. Every complete frame is emitted, including opcode 0x00 and unknown opcodes.
- Timeout counter:
  - Cleared on every accepted byte and whenever the state is `S_B0`.
  - Increments every cycle in any other state.
  - On reaching `TIMEOUT_CYCLES-1` with no byte that cycle: the state returns to `S_B0`, the partial frame is discarded, and `o_error_count` increments.
- Simultaneous byte and timeout expiry: the byte wins. It is accepted, the counter clears, and no error is recorded.
- `o_error_count` saturates at 255. It stays at 255 until reset.
- Reset mid-frame: the partial frame is discarded. All outputs are zero and the state is `S_B0` while `i_rst_n` is low.
- Reset values:
  - `o_instruction` = 0
  - `o_instruction_ready` = 0
  - `o_busy` = 0
  - `o_error_count` = 0
  - timeout counter = 0

## Timing
- `o_instruction` and `o_instruction_ready` are both registered.
- Both update on the clock edge following the cycle in which the final byte is valid (latency 1).
- `o_instruction_ready` is high for exactly one cycle per frame.
- `o_instruction` holds its value until the next complete frame.
- `o_busy` is decoded from the state register, with no input-to-output combinational path.
- Throughput: one instruction per 4 cycles (5 with checksum) with back-to-back bytes.
- `o_error_count` updates on the edge after the timeout or checksum-fail cycle.

## Configuration
- Macro: `INSTR_CHECKSUM_EN`.
- Defined:
  - A fifth byte is required: XOR of byte0..byte3.
  - On a match, the frame is emitted.
  - On a mismatch, nothing is emitted, `o_error_count` increments, and the state returns to `S_B0`.
- Undefined:
  - `S_CHK` and the checksum register do not exist.
  - Frames are exactly 4 bytes.
  - Errors come from timeouts only.

## Structure
- Package `gpu_instr_pkg`:
  - opcode constants `SET_BG_COLOR`=0x01, `SET_RED_BG_COLOR`=0x02, `SET_GREEN_BG_COLOR`=0x03, `SET_BLUE_BG_COLOR`=0x04, `SET_BLACK_BG_COLOR`=0x05, `SET_WHITE_BG_COLOR`=0x06;
  - receiver state enum;
  - `INSTR_W`=32 and `FRAME_BYTES`=4.
- Sub-module `frame_timer`:
  - holds the timeout counter, parameterised by `TIMEOUT_CYCLES`;
  - inputs: clear, enable;
  - output: `expired` pulse.

## Test plan
- Bytes 01,0F,00,00 on consecutive cycles → `o_instruction_ready` high for one cycle, one cycle after byte 3, with `o_instruction`=0x00000F01; `o_busy` back to 0.
- `TIMEOUT_CYCLES`=8, send byte 02, then idle 8 cycles → no strobe, `o_error_count`=1, `o_busy`=0. Then send 03,00,00,00 → `o_instruction`=0x00000003.
- `TIMEOUT_CYCLES`=8, send a byte, then send the next byte exactly on the expiry cycle → accepted, no error. Completing the frame emits it.
- Drop `i_rst_n` after bytes 01,AB; release; send 06,00,00,00 → all outputs 0 during reset, then `o_instruction`=0x00000006, `o_error_count`=0.
- `INSTR_CHECKSUM_EN` defined:
  - 01,0F,00,00,0E → emitted, `o_instruction`=0x00000F01;
  - 01,0F,00,00,FF → no strobe, `o_error_count`=1.
- `TIMEOUT_CYCLES`=8, 300 single-byte aborted frames → `o_error_count` reaches 255 and stays at 255.
